// File: rtl/writeback_unit_pkg.sv
// Shared widths and the write-buffer entry layout for the writeback unit.
package writeback_unit_pkg;

   localparam int WORD_W     = 16;
   localparam int REG_ADDR_W = 5;
   localparam int BANK_SEL_W = 6;

   typedef struct packed {
      logic [BANK_SEL_W-1:0] bank;
      logic [REG_ADDR_W-1:0] addr;
      logic [WORD_W-1:0]     data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_unit_fifo.sv
// In-order write buffer; exposes every slot plus the read pointer so the
// top level can forward the youngest pending value for a register.
module wb_fifo
   import writeback_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  wb_entry_t             push_entry,
   output wb_entry_t             head,
   output logic                  full,
   output logic                  empty,
   output logic [CW-1:0]         count,
   output logic [PW-1:0]         rd_ptr,
   output wb_entry_t [DEPTH-1:0] entries
);

   wb_entry_t [DEPTH-1:0] mem_r;
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;

   // Storage, pointers and occupancy; caller guarantees push/pop legality.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r    <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= push_entry;
            wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head    = mem_r[rd_ptr_r];
   assign full    = (count_r == CW'(DEPTH));
   assign empty   = (count_r == CW'(1'b0));
   assign count   = count_r;
   assign rd_ptr  = rd_ptr_r;
   assign entries = mem_r;

endmodule

// File: rtl/writeback_unit.sv
// Banked register file fed by an execute-stage write buffer and a load-return
// port that owns the single write port; reads forward from pending writes.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int NUM_BANKS = 4,
   parameter int BUF_DEPTH = 4
) (
   input  logic                        clock_i,
   input  logic                        reset_i,
   input  logic                        wbEnable_i,
   input  logic [REG_ADDR_W-1:0]       wbAddress_i,
   input  logic [WORD_W-1:0]           wbData_i,
   input  logic [BANK_SEL_W-1:0]       regBankSelect_i,
   input  logic                        ldWe_i,
   input  logic [BANK_SEL_W-1:0]       ldBank_i,
   input  logic [REG_ADDR_W-1:0]       ldAddr_i,
   input  logic [WORD_W-1:0]           ldData_i,
   input  logic [BANK_SEL_W-1:0]       rdBank_i,
   input  logic [REG_ADDR_W-1:0]       rdAddrA_i,
   input  logic [REG_ADDR_W-1:0]       rdAddrB_i,
   output logic [WORD_W-1:0]           rdDataA_o,
   output logic [WORD_W-1:0]           rdDataB_o,
   output logic                        stall_o,
   output logic [$clog2(BUF_DEPTH):0]  count_o,
   output logic                        overflow_o
);

   localparam int BW      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int IDX_W   = BW + REG_ADDR_W;
   localparam int RF_SIZE = 1 << IDX_W;
   localparam int PW      = $clog2(BUF_DEPTH);
   localparam int CW      = PW + 1;
   localparam logic [BANK_SEL_W-1:0] BANK_MASK = BANK_SEL_W'(NUM_BANKS - 1);

   // Flat regfile index; only the low bank bits select a physical bank.
   function automatic logic [IDX_W-1:0] rf_index(input logic [BANK_SEL_W-1:0] bank,
                                                 input logic [REG_ADDR_W-1:0] addr);
      return {bank[BW-1:0], addr};
   endfunction

   logic [WORD_W-1:0]         rf_r [RF_SIZE];
   wb_entry_t                 push_entry_s;
   wb_entry_t                 head_s;
   wb_entry_t [BUF_DEPTH-1:0] entries_s;
   logic [CW-1:0]             count_s;
   logic [PW-1:0]             rd_ptr_s;
   logic                      full_s, empty_s, pop_s, push_ok_s, drop_s;
   logic                      we_s;
   logic [IDX_W-1:0]          widx_s, idx_a_s, idx_b_s, push_idx_s, ld_idx_s;
   logic [WORD_W-1:0]         wdata_s, fwd_a_s, fwd_b_s, buf_data_a_s, buf_data_b_s;
   logic                      buf_hit_a_s, buf_hit_b_s;
   logic                      overflow_r;
   logic [WORD_W-1:0]         rd_a_r, rd_b_r;

   assign push_entry_s = '{bank: regBankSelect_i & BANK_MASK, addr: wbAddress_i, data: wbData_i};
   assign pop_s        = !ldWe_i && !empty_s;
   assign push_ok_s    = wbEnable_i && (!full_s || pop_s);
   assign drop_s       = wbEnable_i && full_s && !pop_s;
   assign idx_a_s      = rf_index(rdBank_i, rdAddrA_i);
   assign idx_b_s      = rf_index(rdBank_i, rdAddrB_i);
   assign push_idx_s   = rf_index(regBankSelect_i, wbAddress_i);
   assign ld_idx_s     = rf_index(ldBank_i, ldAddr_i);

   wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk        (clock_i),
      .rst_n      (reset_i),
      .push       (push_ok_s),
      .pop        (pop_s),
      .push_entry (push_entry_s),
      .head       (head_s),
      .full       (full_s),
      .empty      (empty_s),
      .count      (count_s),
      .rd_ptr     (rd_ptr_s),
      .entries    (entries_s)
   );

   // Write-port arbitration: a load always wins and holds the buffer back.
   always_comb begin
      if (ldWe_i) begin
         we_s    = 1'b1;
         widx_s  = ld_idx_s;
         wdata_s = ldData_i;
      end else if (pop_s) begin
         we_s    = 1'b1;
         widx_s  = rf_index(head_s.bank, head_s.addr);
         wdata_s = head_s.data;
      end else begin
         we_s    = 1'b0;
         widx_s  = '0;
         wdata_s = '0;
      end
   end

   // Operand forwarding: scan oldest to youngest so the last hit is the youngest.
   always_comb begin : fwd
      logic [PW-1:0]    slot;
      logic [IDX_W-1:0] ent_idx;
      logic             live;
      buf_hit_a_s  = 1'b0;
      buf_hit_b_s  = 1'b0;
      buf_data_a_s = '0;
      buf_data_b_s = '0;
      slot         = rd_ptr_s;
      ent_idx      = '0;
      live         = 1'b0;
      for (int k = 0; k < BUF_DEPTH; k++) begin
         slot         = rd_ptr_s + PW'(k);
         ent_idx      = rf_index(entries_s[slot].bank, entries_s[slot].addr);
         live         = (CW'(k) < count_s);
         buf_data_a_s = (live && ent_idx == idx_a_s) ? entries_s[slot].data : buf_data_a_s;
         buf_data_b_s = (live && ent_idx == idx_b_s) ? entries_s[slot].data : buf_data_b_s;
         buf_hit_a_s  = buf_hit_a_s | (live && ent_idx == idx_a_s);
         buf_hit_b_s  = buf_hit_b_s | (live && ent_idx == idx_b_s);
      end
      if (push_ok_s && push_idx_s == idx_a_s) fwd_a_s = wbData_i;
      else if (buf_hit_a_s)                   fwd_a_s = buf_data_a_s;
      else if (ldWe_i && ld_idx_s == idx_a_s) fwd_a_s = ldData_i;
      else                                    fwd_a_s = rf_r[idx_a_s];
      if (push_ok_s && push_idx_s == idx_b_s) fwd_b_s = wbData_i;
      else if (buf_hit_b_s)                   fwd_b_s = buf_data_b_s;
      else if (ldWe_i && ld_idx_s == idx_b_s) fwd_b_s = ldData_i;
      else                                    fwd_b_s = rf_r[idx_b_s];
   end

   // Register file storage.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < RF_SIZE; i++) rf_r[i] <= '0;
      end else if (we_s) begin
         rf_r[widx_s] <= wdata_s;
      end
   end

   // Registered operands and the sticky drop flag.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         rd_a_r     <= '0;
         rd_b_r     <= '0;
         overflow_r <= 1'b0;
      end else begin
         rd_a_r     <= fwd_a_s;
         rd_b_r     <= fwd_b_s;
         overflow_r <= overflow_r | drop_s;
      end
   end

   assign rdDataA_o  = rd_a_r;
   assign rdDataB_o  = rd_b_r;
   assign overflow_o = overflow_r;
   assign count_o    = count_s;
   assign stall_o    = full_s;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: buffering, forwarding priority, overflow,
// bank aliasing and asynchronous reset.
module tb_writeback_unit;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        wbEnable_i, ldWe_i;
   logic [4:0]  wbAddress_i, ldAddr_i, rdAddrA_i, rdAddrB_i;
   logic [15:0] wbData_i, ldData_i;
   logic [5:0]  regBankSelect_i, ldBank_i, rdBank_i;
   logic [15:0] rdDataA_o, rdDataB_o;
   logic        stall_o, overflow_o;
   logic [2:0]  count_o;
   int          checks = 0;
   int          errors = 0;

   writeback_unit #(.NUM_BANKS(4), .BUF_DEPTH(4)) dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .wbEnable_i(wbEnable_i), .wbAddress_i(wbAddress_i), .wbData_i(wbData_i),
      .regBankSelect_i(regBankSelect_i),
      .ldWe_i(ldWe_i), .ldBank_i(ldBank_i), .ldAddr_i(ldAddr_i), .ldData_i(ldData_i),
      .rdBank_i(rdBank_i), .rdAddrA_i(rdAddrA_i), .rdAddrB_i(rdAddrB_i),
      .rdDataA_o(rdDataA_o), .rdDataB_o(rdDataB_o),
      .stall_o(stall_o), .count_o(count_o), .overflow_o(overflow_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic idle();
      wbEnable_i = 1'b0; wbAddress_i = 5'd0; wbData_i = 16'h0000; regBankSelect_i = 6'd0;
      ldWe_i = 1'b0; ldBank_i = 6'd0; ldAddr_i = 5'd0; ldData_i = 16'h0000;
      rdBank_i = 6'd0; rdAddrA_i = 5'd0; rdAddrB_i = 5'd0;
   endtask

   task automatic push(input logic [5:0] bank, input logic [4:0] addr, input logic [15:0] data);
      wbEnable_i = 1'b1; regBankSelect_i = bank; wbAddress_i = addr; wbData_i = data;
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      idle();
      tick();
      tick();
      reset_i = 1'b1;
   endtask

   task automatic drain();
      wbEnable_i = 1'b0;
      ldWe_i = 1'b0;
      for (int i = 0; i < 10 && count_o != 3'd0; i++) tick();
      checks++;
      if (count_o !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count_o); end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
      checks++;
      if ({stall_o, overflow_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {stall_o, overflow_o}); end
      checks++;
      if ({rdDataA_o, rdDataB_o} !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h expected 0", {rdDataA_o, rdDataB_o}); end
   endtask

   task automatic test_load_hold();
      idle();
      ldWe_i = 1'b1; ldBank_i = 6'd2; ldAddr_i = 5'd9; ldData_i = 16'h5555;
      push(6'd0, 5'd3, 16'h1234);
      rdBank_i = 6'd0; rdAddrA_i = 5'd3;
      tick();
      checks++;
      if (rdDataA_o !== 16'h1234) begin errors++; $display("FAIL hold_push_fwd: got %h expected 1234", rdDataA_o); end
      wbEnable_i = 1'b0;
      tick();
      tick();
      checks++;
      if (count_o !== 3'd1) begin errors++; $display("FAIL hold_count: got %0d expected 1", count_o); end
      checks++;
      if (rdDataA_o !== 16'h1234) begin errors++; $display("FAIL hold_buf_fwd: got %h expected 1234", rdDataA_o); end
      rdBank_i = 6'd2; rdAddrB_i = 5'd9;
      tick();
      checks++;
      if (rdDataB_o !== 16'h5555) begin errors++; $display("FAIL hold_load_rd: got %h expected 5555", rdDataB_o); end
      ldWe_i = 1'b0; rdBank_i = 6'd0; rdAddrA_i = 5'd3;
      tick();
      checks++;
      if (count_o !== 3'd0) begin errors++; $display("FAIL hold_pop_count: got %0d expected 0", count_o); end
      tick();
      checks++;
      if (rdDataA_o !== 16'h1234) begin errors++; $display("FAIL hold_rf_r3: got %h expected 1234", rdDataA_o); end
   endtask

   task automatic test_overflow();
      do_reset();
      ldWe_i = 1'b1; ldBank_i = 6'd3; ldAddr_i = 5'd0; ldData_i = 16'h0001;
      for (int i = 0; i < 4; i++) begin
         push(6'd2, 5'(10 + i), 16'(16'h1000 + i));
         tick();
      end
      checks++;
      if ({count_o, stall_o, overflow_o} !== 5'b100_1_0) begin
         errors++; $display("FAIL full_state: got count=%0d stall=%b ovf=%b expected 4 1 0", count_o, stall_o, overflow_o);
      end
      push(6'd2, 5'd14, 16'h2222);
      rdBank_i = 6'd2; rdAddrA_i = 5'd14; rdAddrB_i = 5'd13;
      tick();
      checks++;
      if ({count_o, stall_o, overflow_o} !== 5'b100_1_1) begin
         errors++; $display("FAIL drop_state: got count=%0d stall=%b ovf=%b expected 4 1 1", count_o, stall_o, overflow_o);
      end
      checks++;
      if (rdDataA_o !== 16'h0000) begin errors++; $display("FAIL drop_not_fwd: got %h expected 0000", rdDataA_o); end
      checks++;
      if (rdDataB_o !== 16'h1003) begin errors++; $display("FAIL full_buf_fwd: got %h expected 1003", rdDataB_o); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      ldWe_i = 1'b1; ldBank_i = 6'd3; ldAddr_i = 5'd1; ldData_i = 16'h0002;
      for (int i = 0; i < 4; i++) begin
         push(6'd1, 5'(20 + i), 16'(16'h3000 + i));
         tick();
      end
      ldWe_i = 1'b0;
      push(6'd1, 5'd24, 16'h3004);
      tick();
      checks++;
      if ({count_o, stall_o, overflow_o} !== 5'b100_1_0) begin
         errors++; $display("FAIL pushpop_state: got count=%0d stall=%b ovf=%b expected 4 1 0", count_o, stall_o, overflow_o);
      end
      drain();
      rdBank_i = 6'd1; rdAddrA_i = 5'd20; rdAddrB_i = 5'd24;
      tick();
      checks++;
      if ({rdDataA_o, rdDataB_o} !== 32'h3000_3004) begin
         errors++; $display("FAIL pushpop_rf: got %h expected 30003004", {rdDataA_o, rdDataB_o});
      end
      checks++;
      if (stall_o !== 1'b0) begin errors++; $display("FAIL pushpop_stall: got %b expected 0", stall_o); end
   endtask

   task automatic test_ordering();
      idle();
      ldWe_i = 1'b1; ldBank_i = 6'd0; ldAddr_i = 5'd31; ldData_i = 16'h0000;
      push(6'd1, 5'd5, 16'hAAAA);
      tick();
      push(6'd1, 5'd5, 16'hBBBB);
      tick();
      wbEnable_i = 1'b0; rdBank_i = 6'd1; rdAddrA_i = 5'd5;
      tick();
      checks++;
      if (rdDataA_o !== 16'hBBBB) begin errors++; $display("FAIL order_youngest: got %h expected BBBB", rdDataA_o); end
      rdBank_i = 6'd0;
      tick();
      checks++;
      if (rdDataA_o !== 16'h0000) begin errors++; $display("FAIL order_bank0: got %h expected 0000", rdDataA_o); end
      rdBank_i = 6'd1;
      push(6'd1, 5'd5, 16'hCCCC);
      tick();
      checks++;
      if (rdDataA_o !== 16'hCCCC) begin errors++; $display("FAIL order_push_prio: got %h expected CCCC", rdDataA_o); end
      push(6'd0, 5'd8, 16'h1111);
      tick();
      wbEnable_i = 1'b0;
      ldBank_i = 6'd0; ldAddr_i = 5'd8; ldData_i = 16'h2222;
      rdBank_i = 6'd0; rdAddrA_i = 5'd8;
      tick();
      checks++;
      if (rdDataA_o !== 16'h1111) begin errors++; $display("FAIL order_buf_over_load: got %h expected 1111", rdDataA_o); end
      drain();
      tick();
      checks++;
      if (rdDataA_o !== 16'h1111) begin errors++; $display("FAIL order_drain_overwrites_load: got %h expected 1111", rdDataA_o); end
      rdBank_i = 6'd1; rdAddrA_i = 5'd5;
      tick();
      checks++;
      if (rdDataA_o !== 16'hCCCC) begin errors++; $display("FAIL order_rf_r5: got %h expected CCCC", rdDataA_o); end
   endtask

   task automatic test_alias();
      idle();
      push(6'd5, 5'd7, 16'h00FF);
      tick();
      wbEnable_i = 1'b0;
      tick();
      rdBank_i = 6'd1; rdAddrA_i = 5'd7;
      tick();
      checks++;
      if (rdDataA_o !== 16'h00FF || count_o !== 3'd0) begin
         errors++; $display("FAIL alias_bank1: got %h count=%0d expected 00FF count=0", rdDataA_o, count_o);
      end
      rdBank_i = 6'd41;
      tick();
      checks++;
      if (rdDataA_o !== 16'h00FF) begin errors++; $display("FAIL alias_bank41: got %h expected 00FF", rdDataA_o); end
   endtask

   task automatic test_reset_mid();
      idle();
      ldWe_i = 1'b1; ldBank_i = 6'd3; ldAddr_i = 5'd2; ldData_i = 16'h0003;
      push(6'd0, 5'd1, 16'hD001); tick();
      push(6'd0, 5'd2, 16'hD002); tick();
      push(6'd0, 5'd4, 16'hD004); tick();
      wbEnable_i = 1'b0; rdBank_i = 6'd0; rdAddrA_i = 5'd1; rdAddrB_i = 5'd4;
      tick();
      checks++;
      if ({rdDataA_o, rdDataB_o, count_o} !== {16'hD001, 16'hD004, 3'd3}) begin
         errors++; $display("FAIL pre_reset: got %h %h %0d expected D001 D004 3", rdDataA_o, rdDataB_o, count_o);
      end
      #3 reset_i = 1'b0;
      #1;
      checks++;
      if ({rdDataA_o, rdDataB_o, count_o, stall_o, overflow_o} !== 37'h0) begin
         errors++; $display("FAIL async_reset: got %h %h %0d %b %b expected all 0", rdDataA_o, rdDataB_o, count_o, stall_o, overflow_o);
      end
      #1;
      idle();
      rdAddrA_i = 5'd1; rdAddrB_i = 5'd2;
      push(6'd0, 5'd30, 16'h7777);
      reset_i = 1'b1;
      tick();
      checks++;
      if (count_o !== 3'd1) begin errors++; $display("FAIL first_push_after_reset: got %0d expected 1", count_o); end
      checks++;
      if ({rdDataA_o, rdDataB_o} !== 32'h0) begin errors++; $display("FAIL no_partial_write: got %h expected 0", {rdDataA_o, rdDataB_o}); end
      wbEnable_i = 1'b0; rdAddrA_i = 5'd30; rdAddrB_i = 5'd4;
      tick();
      tick();
      checks++;
      if ({rdDataA_o, rdDataB_o, count_o} !== {16'h7777, 16'h0000, 3'd0}) begin
         errors++; $display("FAIL post_reset_drain: got %h %h %0d expected 7777 0000 0", rdDataA_o, rdDataB_o, count_o);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_load_hold();
      test_overflow();
      test_full_push_pop();
      test_ordering();
      test_alias();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of physical register banks (power of 2, ≤64).
REQ-002 SHALL have parameter BUF_DEPTH, default 4, write-buffer entries (power of 2).
REQ-003 SHALL have ports: clock_i  in  1  single clock, rising-edge.
REQ-004 SHALL have ports: reset_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: wbEnable_i  in  1, wbAddress_i  in  5, wbData_i  in  16, regBankSelect_i  in  6  result from execute stage.
REQ-006 SHALL have ports: ldWe_i  in  1, ldBank_i  in  6, ldAddr_i  in  5, ldData_i  in  16  load-return write, owns regfile port.
REQ-007 SHALL have ports: rdBank_i  in  6, rdAddrA_i  in  5, rdAddrB_i  in  5  operand read request.
REQ-008 SHALL have ports: rdDataA_o  out  16, rdDataB_o  out  16  registered operands.
REQ-009 SHALL have ports: stall_o  out  1  buffer cannot accept; count_o  out  log2(BUF_DEPTH)+1  occupancy; overflow_o  out  1  sticky drop error.

Function
REQ-010 Bank index SHALL be the low log2(NUM_BANKS) bits of any 6-bit bank input; upper bits ignored.
REQ-011 Register file SHALL be NUM_BANKS x 32 x 16-bit, one write port, two read ports; register 0 not special.
REQ-012 wbEnable_i=1 SHALL push {bank, wbAddress_i, wbData_i} into an in-order FIFO write buffer at the clock edge.
REQ-013 Push SHALL be accepted iff count<BUF_DEPTH or a pop occurs the same cycle (full + push + pop: accepted, count unchanged).
REQ-014 Push while full with no pop SHALL drop the entry and set overflow_o=1 until reset.
REQ-015 stall_o SHALL equal (count_o==BUF_DEPTH), combinational from registered count.
REQ-016 Pop: when ldWe_i=0 and count>0, head entry SHALL write the regfile and leave the buffer in that cycle.
REQ-017 When ldWe_i=1 the load SHALL write the regfile and no pop SHALL occur; buffer waits.
REQ-018 Pushed entry SHALL not pop in the same cycle it is pushed (minimum residency 1 cycle).
REQ-019 Reads SHALL have 1-cycle latency: rdData*_o at edge N+1 reflects request at cycle N.
REQ-020 Read value priority for matching {bank,addr}: same-cycle accepted push > youngest buffered entry > same-cycle load write > regfile contents.
REQ-021 A load write to a register with a pending buffered entry SHALL be overwritten when that entry drains (defined ordering).
REQ-022 Buffer read/write pointers SHALL wrap modulo BUF_DEPTH; count_o SHALL track push/pop exactly.

Reset
REQ-023 reset_i low SHALL immediately clear all registers, buffer pointers, count_o, overflow_o, rdDataA_o, rdDataB_o to 0.
REQ-024 Reset mid-drain SHALL discard all buffered entries; no partial regfile write.
REQ-025 After release, first push SHALL be accepted on the first rising edge with reset_i high.

Structure
REQ-026 Shared package SHALL hold WORD_W=16, REG_ADDR_W=5, BANK_SEL_W=6 and the buffer-entry struct {bank, addr, data}.
REQ-027 Write buffer SHALL be a sub-module wb_fifo (push/pop/full/empty/count plus parallel entry view for forwarding).

Verification
REQ-028 Push bank0 r3=0x1234 with ldWe_i=1 held 3 cycles -> count_o=1, read r3 returns 0x1234 from buffer; ldWe_i low -> regfile r3=0x1234 next cycle, count_o=0.
REQ-029 Hold ldWe_i=1, push 4 entries -> stall_o=1; 5th push -> dropped, overflow_o=1, count_o=4.
REQ-030 Full buffer, ldWe_i=0, push same cycle -> pop and push both occur, count_o stays 4, overflow_o=0.
REQ-031 Push r5=0xAAAA then r5=0xBBBB (bank 1), read r5 bank 1 while buffered -> 0xBBBB; bank 0 r5 -> 0x0000.
REQ-032 regBankSelect_i=6'd5 write r7=0x00FF, read rdBank_i=6'd1 r7 after drain -> 0x00FF (NUM_BANKS=4 aliasing).
REQ-033 Assert reset_i low with 3 entries buffered, mid-cycle -> outputs 0 immediately, count_o=0, regfile untouched by pending entries.
